// File: rtl/dfft_pulse_bank.sv
// Bank of toggle-encoded destructive flip-flops sharing one readout clock.
// Lost data pulses are flagged per channel and counted with saturation.
module dfft_pulse_bank #(
    parameter int WIDTH    = 4,
    parameter int LAT      = 1,
    parameter int SIM_PRIO = 0,
    parameter int CW       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic             ck,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] err,
    output logic [CW-1:0]    lost_cnt
);
    localparam int CNTW = $clog2(WIDTH + 1) + 1;
    localparam int SW   = ((CW > CNTW) ? CW : CNTW) + 1;

    logic [WIDTH-1:0] a_smp_r;
    logic             ck_smp_r;
    logic             armed_r;
    logic [WIDTH-1:0] st_r;

    logic [WIDTH-1:0] a_pls_s;
    logic             ck_pls_s;
    logic [WIDTH-1:0] rd_s;
    logic [WIDTH-1:0] st_nxt_s;
    logic [WIDTH-1:0] lost_s;
    logic [WIDTH-1:0] err_nxt_s;
    logic [WIDTH-1:0] tgl_s;
    logic [SW-1:0]    base_s;
    logic [SW-1:0]    sum_s;
    logic [CW-1:0]    cnt_nxt_s;

    function automatic logic [CNTW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CNTW-1:0] c;
        c = {CNTW{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            c = c + {{(CNTW-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Edge detection and per-channel store/readout/loss decision
    always_comb begin
        a_pls_s  = armed_r ? (a ^ a_smp_r) : {WIDTH{1'b0}};
        ck_pls_s = armed_r & (ck ^ ck_smp_r);
        rd_s     = {WIDTH{1'b0}};
        lost_s   = {WIDTH{1'b0}};
        st_nxt_s = st_r;
        for (int i = 0; i < WIDTH; i++) begin
            if (a_pls_s[i] && ck_pls_s) begin
                // Clock-first keeps the new pulse; data-first reads out and drops it
                if (SIM_PRIO == 0) begin
                    rd_s[i]     = st_r[i];
                    st_nxt_s[i] = 1'b1;
                end else begin
                    rd_s[i]     = 1'b1;
                    lost_s[i]   = st_r[i];
                    st_nxt_s[i] = 1'b0;
                end
            end else if (a_pls_s[i]) begin
                lost_s[i]   = st_r[i];
                st_nxt_s[i] = 1'b1;
            end else if (ck_pls_s) begin
                rd_s[i]     = st_r[i];
                st_nxt_s[i] = 1'b0;
            end else begin
                st_nxt_s[i] = st_r[i];
            end
        end
    end

    // Error flags and saturating loss counter; clear applies before new losses
    always_comb begin
        err_nxt_s = (clr_err ? {WIDTH{1'b0}} : err) | lost_s;
        base_s    = clr_err ? {SW{1'b0}} : {{(SW-CW){1'b0}}, lost_cnt};
        sum_s     = base_s + {{(SW-CNTW){1'b0}}, popcount(lost_s)};
        if (sum_s > {{(SW-CW){1'b0}}, {CW{1'b1}}}) begin
            cnt_nxt_s = {CW{1'b1}};
        end else begin
            cnt_nxt_s = sum_s[CW-1:0];
        end
    end

    generate
        if (LAT == 0) begin : g_nolat
            assign tgl_s = rd_s;
        end else begin : g_lat
            logic [WIDTH-1:0] pipe_r [LAT];
            // Readout delay line, one stage per extra cycle of latency
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int j = 0; j < LAT; j++) begin
                        pipe_r[j] <= {WIDTH{1'b0}};
                    end
                end else begin
                    pipe_r[0] <= rd_s;
                    for (int j = 1; j < LAT; j++) begin
                        pipe_r[j] <= pipe_r[j-1];
                    end
                end
            end
            assign tgl_s = pipe_r[LAT-1];
        end
    endgenerate

    // Input samples, channel state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_smp_r  <= {WIDTH{1'b0}};
            ck_smp_r <= 1'b0;
            armed_r  <= 1'b0;
            st_r     <= {WIDTH{1'b0}};
            q        <= {WIDTH{1'b0}};
            err      <= {WIDTH{1'b0}};
            lost_cnt <= {CW{1'b0}};
        end else begin
            a_smp_r  <= a;
            ck_smp_r <= ck;
            armed_r  <= 1'b1;
            st_r     <= st_nxt_s;
            q        <= q ^ tgl_s;
            err      <= err_nxt_s;
            lost_cnt <= cnt_nxt_s;
        end
    end
endmodule

// File: doc/dfft_pulse_bank.md
DFFT_PULSE_BANK -- requirements
Module: dfft_pulse_bank

Interface
REQ-001 Parameter WIDTH, default 4: number of independent DFFT channels.
REQ-002 Parameter LAT, default 1, legal range 0..8: extra clk cycles between a clock-pulse readout and the q toggle.
REQ-003 Parameter SIM_PRIO, default 0: same-edge data/clock ordering. 0 = clock first, 1 = data first.
REQ-004 Parameter CW, default 8: width of the lost-pulse counter.
REQ-005 clk  input  1: single system clock; all state updates on its rising edge.
REQ-006 rst  input  1: asynchronous, active-high reset.
REQ-007 a  input  WIDTH: toggle-encoded data pulses; each transition of a[i] is one pulse on channel i.
REQ-008 ck  input  1: toggle-encoded readout clock pulse, shared by all channels; each transition is one pulse.
REQ-009 clr_err  input  1: synchronous clear of err and lost_cnt.
REQ-010 q  output  WIDTH: toggle-encoded output; q[i] flips once per delivered readout.
REQ-011 err  output  WIDTH: sticky per-channel lost-pulse flag.
REQ-012 lost_cnt  output  CW: saturating count of lost data pulses, summed over all channels.

Function
REQ-013 Pulse detection: a pulse is registered at rising edge k when the input sampled at edge k differs from the input sampled at edge k-1. Applies per bit of a, and to ck.
REQ-014 Arming: the first rising edge after rst deasserts only captures a and ck and detects no pulses, whatever their levels.
REQ-015 Storage: each channel holds a one-bit state, 0 = empty, 1 = holding a pulse.
REQ-016 State transitions with no same-edge conflict:
- a-pulse: 0->1.
- ck-pulse with state 1: readout issued, state 1->0.
- ck-pulse with state 0: no effect.
REQ-017 SIM_PRIO=0, a-pulse and ck-pulse at the same edge: readout is issued if and only if the pre-edge state is 1, and the next state is 1.
REQ-018 SIM_PRIO=1, a-pulse and ck-pulse at the same edge: readout is always issued, and the next state is 0.
REQ-019 Lost pulse: an a-pulse is lost when it cannot be stored. This occurs when:
- state is 1 and there is no ck-pulse; or
- state is 1, there is a ck-pulse, and SIM_PRIO=1.
A lost pulse leaves state unchanged apart from any readout.
REQ-020 Latency: a readout issued at edge m toggles q[i] at edge m+LAT; with LAT=0 the toggle occurs at edge m.
REQ-021 Delay line: readout requests pass through a LAT-deep per-channel shift pipeline. Readouts issued on consecutive edges each produce exactly one toggle, with none merged or dropped.
REQ-022 err[i] is set at any edge where channel i loses a pulse, and is cleared only by clr_err or rst.
REQ-023 lost_cnt adds the number of channels losing a pulse at each edge, saturating at 2^CW-1 with no wrap-around.
REQ-024 clr_err at an edge that also records losses: clear first, then apply the new losses, so err reflects that edge's losses and lost_cnt equals that edge's loss count.
REQ-025 q, err and lost_cnt are driven directly from registers, with no combinational path from any input.

Reset
REQ-026 While rst is high, all of the following are 0:
- q, err, lost_cnt;
- channel states;
- delay-pipeline contents;
- the arming flag and the edge-detect samples.
REQ-027 Reset mid-operation: readouts in flight in the pipeline are discarded, so no q toggle occurs after reset, and stored pulses are lost without being counted.
REQ-028 After rst deasserts, behaviour restarts from the arming edge defined in REQ-014.

Verification
REQ-029 The bench SHALL cover the following directed scenarios (WIDTH=4, LAT=1, CW=8 unless stated):
- Basic readout: a[0] toggles (pulse at edge 5), then ck toggles (pulse at edge 8) -> q[0] flips 0->1 at edge 9; other q bits stay 0; err=0.
- Lost pulse: a[2] pulses at edges 3 and 4 with no ck, then ck pulses at edge 6 -> err[2]=1 from edge 4; lost_cnt=1; q[2] toggles exactly once, at edge 7.
- Simultaneous events, stored pulse at edge 2, a[1] and ck pulse together at edge 5:
  - SIM_PRIO=0: q[1] toggles at edge 6, state stays 1, and a second ck pulse gives a second toggle.
  - SIM_PRIO=1: q[1] toggles at edge 6, lost_cnt=1, and a second ck pulse gives no toggle.
- Saturation: CW=2, repeated multi-channel losses -> lost_cnt sticks at 3. clr_err at the same edge as a 2-channel loss -> lost_cnt=2.
- Reset: rst asserted one cycle after a readout is issued with LAT=3 -> q remains 0 during and after reset. a held high across the rst release -> no pulse is detected at the arming edge.
